// File: rtl/proc_control_unit_if.sv
// Control bus between the processor control FSM and the datapath.
// The master side (control unit) receives IR and drives every datapath strobe
// plus the State/NextState codes used by the HEX display.
interface proc_control_unit_if;
    localparam int unsigned IR_W   = 16;
    localparam int unsigned D_AW   = 8;
    localparam int unsigned RF_AW  = 4;
    localparam int unsigned ALU_SW = 3;
    localparam int unsigned ST_W   = 4;

    logic [IR_W-1:0]   IR;
    logic              PC_clr;
    logic              PC_up;
    logic              IR_ld;
    logic [D_AW-1:0]   D_addr;
    logic              D_wr;
    logic              RF_s;
    logic [RF_AW-1:0]  RF_W_addr;
    logic              RF_W_en;
    logic [RF_AW-1:0]  RF_Ra_addr;
    logic [RF_AW-1:0]  RF_Rb_addr;
    logic [ALU_SW-1:0] ALU_s0;
    logic [ST_W-1:0]   State;
    logic [ST_W-1:0]   NextState;
    logic              Halted;

    modport master (
        input  IR,
        output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, State, NextState, Halted
    );

    modport slave (
        output IR,
        input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, State, NextState, Halted
    );
endinterface

// File: rtl/proc_control_unit.sv
// Moore control FSM for the single-cycle-datapath processor.
// Sequences FETCH/DECODE/execute and decodes datapath strobes from State and IR.
// Optional feature macro: PROC_ILLEGAL_TRAP_EN -- when defined, opcodes 0110-1111
// enter a sticky TRAP state (code 10); otherwise they execute as NOOP.
module proc_control_unit (
    input  logic                   Clk,
    input  logic                   ResetN,
    proc_control_unit_if.master    bus
);
    localparam int unsigned IR_W   = 16;
    localparam int unsigned ALU_SW = 3;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    localparam logic [ALU_SW-1:0] ALU_ADD = 3'b001;
    localparam logic [ALU_SW-1:0] ALU_SUB = 3'b010;

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        NOOP   = 4'd3,
        LOAD_A = 4'd4,
        LOAD_B = 4'd5,
        STORE  = 4'd6,
        ADD    = 4'd7,
        SUB    = 4'd8,
        HALT   = 4'd9
`ifdef PROC_ILLEGAL_TRAP_EN
        , TRAP = 4'd10
`endif
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [IR_W-1:0] ir;
    logic [3:0]      opcode;

    assign ir     = bus.IR;
    assign opcode = ir[15:12];

    // State register; reset lands in INIT immediately, aborting any instruction.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; HALT and TRAP only leave through reset.
    always_comb begin
        next_state = state;
        case (state)
            INIT:   next_state = FETCH;
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_NOOP:  next_state = NOOP;
                    OP_STORE: next_state = STORE;
                    OP_LOAD:  next_state = LOAD_A;
                    OP_ADD:   next_state = ADD;
                    OP_SUB:   next_state = SUB;
                    OP_HALT:  next_state = HALT;
`ifdef PROC_ILLEGAL_TRAP_EN
                    default:  next_state = TRAP;
`else
                    default:  next_state = NOOP;
`endif
                endcase
            end
            LOAD_A: next_state = LOAD_B;
            NOOP,
            LOAD_B,
            STORE,
            ADD,
            SUB:    next_state = FETCH;
            HALT:   next_state = HALT;
`ifdef PROC_ILLEGAL_TRAP_EN
            TRAP:   next_state = TRAP;
`endif
            default: next_state = INIT;
        endcase
    end

    // Datapath strobes decoded from the current state and IR fields.
    always_comb begin
        bus.PC_clr     = 1'b0;
        bus.PC_up      = 1'b0;
        bus.IR_ld      = 1'b0;
        bus.D_addr     = '0;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = '0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_addr = '0;
        bus.RF_Rb_addr = '0;
        bus.ALU_s0     = '0;
        bus.Halted     = 1'b0;
        case (state)
            INIT: bus.PC_clr = 1'b1;
            FETCH: begin
                bus.IR_ld = 1'b1;
                bus.PC_up = 1'b1;
            end
            // First load cycle only presents the address: memory read has one cycle of latency.
            LOAD_A: begin
                bus.D_addr    = ir[11:4];
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = ir[3:0];
            end
            LOAD_B: begin
                bus.D_addr    = ir[11:4];
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = ir[3:0];
                bus.RF_W_en   = 1'b1;
            end
            STORE: begin
                bus.D_addr     = ir[11:4];
                bus.RF_Ra_addr = ir[3:0];
                bus.D_wr       = 1'b1;
            end
            ADD, SUB: begin
                bus.RF_Ra_addr = ir[11:8];
                bus.RF_Rb_addr = ir[7:4];
                bus.RF_W_addr  = ir[3:0];
                bus.RF_W_en    = 1'b1;
                bus.ALU_s0     = (state == ADD) ? ALU_ADD : ALU_SUB;
            end
            HALT: bus.Halted = 1'b1;
`ifdef PROC_ILLEGAL_TRAP_EN
            TRAP: bus.Halted = 1'b1;
`endif
            default: ;
        endcase
    end

    assign bus.State     = 4'(state);
    assign bus.NextState = 4'(next_state);
endmodule

// File: tb/tb_proc_control_unit.sv
// Directed self-checking bench for proc_control_unit.
// The bench plays the datapath: it presents IR after each FETCH and compares the
// full output vector against hand-computed values every cycle.
module tb_proc_control_unit;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    proc_control_unit_if bus ();

    proc_control_unit dut (
        .Clk    (clk),
        .ResetN (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed in a fixed order for single-shot comparison.
    function automatic logic [37:0] obs();
        return {bus.State, bus.NextState, bus.PC_clr, bus.PC_up, bus.IR_ld,
                bus.D_addr, bus.D_wr, bus.RF_s, bus.RF_W_addr, bus.RF_W_en,
                bus.RF_Ra_addr, bus.RF_Rb_addr, bus.ALU_s0, bus.Halted};
    endfunction

    // Expected output vector in the same order as obs().
    function automatic logic [37:0] ev(input int st, input int nx, input int clr,
                                       input int up, input int ld, input int da,
                                       input int dw, input int rs, input int wa,
                                       input int we, input int ra, input int rb,
                                       input int alu, input int h);
        return {4'(st), 4'(nx), 1'(clr), 1'(up), 1'(ld), 8'(da), 1'(dw), 1'(rs),
                4'(wa), 1'(we), 4'(ra), 4'(rb), 3'(alu), 1'(h)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock, sample just after the edge, and check the global invariants.
    task automatic step();
        @(posedge clk);
        #1;
        check("wr_exclusive", 64'(bus.D_wr & bus.RF_W_en), 64'd0);
        check("pc_up_only_fetch", 64'(bus.PC_up & (bus.State != 4'd1)), 64'd0);
    endtask

    // FETCH cycle, then present the instruction and check DECODE's next-state choice.
    task automatic do_fetch(input logic [15:0] ir, input int nx);
        step();
        check("fetch", 64'(obs()), 64'(ev(1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        bus.IR = ir;
        step();
        check("decode", 64'(obs()), 64'(ev(2, nx, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    endtask

    // Mid-cycle async reset, immediate INIT check, release on the falling edge.
    task automatic reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check(tag, 64'(obs()), 64'(ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_after_release", 64'(obs()), 64'(ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.IR  = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'(obs()), 64'(ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD r3 <- mem[A5]: two execute cycles, write only in the second.
        do_fetch(16'h2A53, 4);
        step();
        check("load_a", 64'(obs()), 64'(ev(4, 5, 0, 0, 0, 8'hA5, 0, 1, 3, 0, 0, 0, 0, 0)));
        step();
        check("load_b", 64'(obs()), 64'(ev(5, 1, 0, 0, 0, 8'hA5, 0, 1, 3, 1, 0, 0, 0, 0)));

        // STORE mem[B7] <- r2.
        do_fetch(16'h1B72, 6);
        step();
        check("store", 64'(obs()), 64'(ev(6, 1, 0, 0, 0, 8'hB7, 1, 0, 0, 0, 2, 0, 0, 0)));

        // ADD r4 <- r1 + r2.
        do_fetch(16'h3124, 7);
        step();
        check("add", 64'(obs()), 64'(ev(7, 1, 0, 0, 0, 0, 0, 0, 4, 1, 1, 2, 1, 0)));

        // SUB r4 <- r1 - r2.
        do_fetch(16'h4124, 8);
        step();
        check("sub", 64'(obs()), 64'(ev(8, 1, 0, 0, 0, 0, 0, 0, 4, 1, 1, 2, 2, 0)));

        // NOOP.
        do_fetch(16'h0000, 3);
        step();
        check("noop", 64'(obs()), 64'(ev(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

        // Illegal opcode.
`ifdef PROC_ILLEGAL_TRAP_EN
        do_fetch(16'hF000, 10);
        repeat (3) begin
            step();
            check("trap_hold", 64'(obs()), 64'(ev(10, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
        end
        reset_pulse("trap_reset");
`else
        do_fetch(16'hF000, 3);
        step();
        check("illegal_noop", 64'(obs()), 64'(ev(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
`endif

        // Reset in the middle of a LOAD: no LOAD_B write may follow.
        do_fetch(16'h2A53, 4);
        step();
        check("load_a_pre_reset", 64'(obs()), 64'(ev(4, 5, 0, 0, 0, 8'hA5, 0, 1, 3, 0, 0, 0, 0, 0)));
        reset_pulse("async_reset_mid");
        step();
        check("post_reset_fetch", 64'(obs()), 64'(ev(1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        bus.IR = 16'h5000;
        step();
        check("post_reset_decode", 64'(obs()), 64'(ev(2, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

        // HALT holds for 20 clocks with all strobes low.
        repeat (20) begin
            step();
            check("halt_hold", 64'(obs()), 64'(ev(9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
        end
        reset_pulse("halt_reset");
        do_fetch(16'h3124, 7);
        step();
        check("add_after_halt", 64'(obs()), 64'(ev(7, 1, 0, 0, 0, 0, 0, 0, 4, 1, 1, 2, 1, 0)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
